// File: rtl/aes_acc_pkg.sv
// ============================================================================
// Module      : aes_acc_pkg
// Description : Shared widths and the state-beat type for the AES datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_acc_pkg;

   localparam int c_data_w_default = 64;
   localparam int c_tag_w_default  = 4;
   localparam int c_stages_max     = 4;

   typedef struct packed {
      logic [c_data_w_default-1:0] hi;
      logic [c_data_w_default-1:0] lo;
      logic [c_tag_w_default-1:0]  tag;
   } state_beat_t;

endpackage

`default_nettype wire

// File: rtl/add_round_key_pipe_slot.sv
// ============================================================================
// Module      : pipe_skid_slot
// Description : One valid/ready register slot with a parametrised payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_slot #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [PAYLOAD_W-1:0] i_data,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [PAYLOAD_W-1:0] o_data
);

   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_data;

   // Accept when empty or when the held beat leaves this same cycle.
   assign i_ready = !r_valid || o_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_valid && i_ready) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (o_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/add_round_key_pipe.sv
// ============================================================================
// Module      : add_round_key_pipe
// Description : Pipelined AES AddRoundKey with valid/ready, tag and skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_round_key_pipe
   import aes_acc_pkg::*;
#(
   parameter int DATA_W = c_data_w_default,
   parameter int STAGES = 2,
   parameter int TAG_W  = c_tag_w_default
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_data_in_higher,
   input  logic [DATA_W-1:0] i_data_in_lower,
   input  logic [DATA_W-1:0] i_key_in_higher,
   input  logic [DATA_W-1:0] i_key_in_lower,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic              i_valid,
   output logic              i_ready,
   output logic [DATA_W-1:0] o_data_out_higher,
   output logic [DATA_W-1:0] o_data_out_lower,
   output logic [TAG_W-1:0]  o_tag,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              o_busy
);

   localparam int c_beat_w = 2*DATA_W + TAG_W;

   if (STAGES < 1 || STAGES > c_stages_max) begin : g_stages_check
      $error("add_round_key_pipe: STAGES must be in 1..%0d", c_stages_max);
   end

   // Index k is the handshake entering slot k; index STAGES is the output.
   logic [STAGES:0]     w_valid;
   logic [STAGES:0]     w_ready;
   logic [c_beat_w-1:0] w_data [STAGES+1];

   logic [c_beat_w-1:0] w_in_beat;
   logic                w_accept;
   logic                w_skid_valid;
   logic                w_skid_in_ready;
   logic [c_beat_w-1:0] w_skid_data;

   assign w_in_beat = {i_data_in_higher ^ i_key_in_higher,
                       i_data_in_lower  ^ i_key_in_lower,
                       i_tag};

   assign i_ready  = !w_skid_valid;
   assign w_accept = i_valid && i_ready;

   // A waiting skid beat always goes first so ordering is preserved.
   assign w_valid[0] = w_skid_valid || w_accept;
   assign w_data[0]  = w_skid_valid ? w_skid_data : w_in_beat;

   pipe_skid_slot #(
      .PAYLOAD_W (c_beat_w)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_accept && !w_ready[0] && w_skid_in_ready),
      .i_ready (w_skid_in_ready),
      .i_data  (w_in_beat),
      .o_valid (w_skid_valid),
      .o_ready (w_ready[0]),
      .o_data  (w_skid_data)
   );

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      pipe_skid_slot #(
         .PAYLOAD_W (c_beat_w)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .i_valid (w_valid[k]),
         .i_ready (w_ready[k]),
         .i_data  (w_data[k]),
         .o_valid (w_valid[k+1]),
         .o_ready (w_ready[k+1]),
         .o_data  (w_data[k+1])
      );
   end

   assign w_ready[STAGES] = o_ready;
   assign o_valid         = w_valid[STAGES];
   assign {o_data_out_higher, o_data_out_lower, o_tag} = w_data[STAGES];
   assign o_busy          = (|w_valid[STAGES:1]) || w_skid_valid;

endmodule

`default_nettype wire

// File: tb/tb_add_round_key_pipe.sv
// ============================================================================
// Module      : tb_add_round_key_pipe
// Description : Directed/scoreboard bench for add_round_key_pipe (STAGES 1,2,4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_round_key_pipe;
   import aes_acc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] d_hi, d_lo, k_hi, k_lo;
   logic [3:0]  tg;

   logic        in_v1, in_rdy1, out_v1, out_rdy1, busy1;
   logic [63:0] out_hi1, out_lo1;
   logic [3:0]  out_tag1;
   logic        in_v2, in_rdy2, out_v2, out_rdy2, busy2;
   logic [63:0] out_hi2, out_lo2;
   logic [3:0]  out_tag2;
   logic        in_v4, in_rdy4, out_v4, out_rdy4, busy4;
   logic [63:0] out_hi4, out_lo4;
   logic [3:0]  out_tag4;

   add_round_key_pipe #(.DATA_W(64), .STAGES(1), .TAG_W(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .i_data_in_higher(d_hi), .i_data_in_lower(d_lo),
      .i_key_in_higher(k_hi), .i_key_in_lower(k_lo), .i_tag(tg),
      .i_valid(in_v1), .i_ready(in_rdy1),
      .o_data_out_higher(out_hi1), .o_data_out_lower(out_lo1), .o_tag(out_tag1),
      .o_valid(out_v1), .o_ready(out_rdy1), .o_busy(busy1));

   add_round_key_pipe #(.DATA_W(64), .STAGES(2), .TAG_W(4)) u_dut2 (
      .clk(clk), .rst(rst),
      .i_data_in_higher(d_hi), .i_data_in_lower(d_lo),
      .i_key_in_higher(k_hi), .i_key_in_lower(k_lo), .i_tag(tg),
      .i_valid(in_v2), .i_ready(in_rdy2),
      .o_data_out_higher(out_hi2), .o_data_out_lower(out_lo2), .o_tag(out_tag2),
      .o_valid(out_v2), .o_ready(out_rdy2), .o_busy(busy2));

   add_round_key_pipe #(.DATA_W(64), .STAGES(4), .TAG_W(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .i_data_in_higher(d_hi), .i_data_in_lower(d_lo),
      .i_key_in_higher(k_hi), .i_key_in_lower(k_lo), .i_tag(tg),
      .i_valid(in_v4), .i_ready(in_rdy4),
      .o_data_out_higher(out_hi4), .o_data_out_lower(out_lo4), .o_tag(out_tag4),
      .o_valid(out_v4), .o_ready(out_rdy4), .o_busy(busy4));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard on the STAGES=2 instance: expected beats queued at acceptance.
   state_beat_t sb_q[$];
   state_beat_t mon_beat;
   int          n_out = 0;

   always @(posedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (out_v2 && out_rdy2) begin
            if (sb_q.size() == 0) check("unexpected_beat", out_v2, 1'b0);
            else begin
               check("scoreboard", {out_hi2, out_lo2, out_tag2}, sb_q.pop_front());
               n_out++;
            end
         end
         if (in_v2 && in_rdy2) begin
            mon_beat.hi  = d_hi ^ k_hi;
            mon_beat.lo  = d_lo ^ k_lo;
            mon_beat.tag = tg;
            sb_q.push_back(mon_beat);
         end
      end
   end

   initial begin
      int          acc, lat, sent, cyc, base;
      logic [63:0] e_hi, e_lo;

      rst = 1'b1;
      d_hi = '0; d_lo = '0; k_hi = '0; k_lo = '0; tg = '0;
      in_v1 = 1'b0; in_v2 = 1'b0; in_v4 = 1'b0;
      out_rdy1 = 1'b1; out_rdy2 = 1'b1; out_rdy4 = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("reset_state", {out_v2, busy2, in_rdy2, out_hi2, out_lo2, out_tag2},
            {1'b0, 1'b0, 1'b1, 132'h0});

      // Single beat through STAGES=2
      d_hi = 64'h0123456789ABCDEF; d_lo = 64'hFEDCBA9876543210;
      k_hi = 64'hFFFFFFFFFFFFFFFF; k_lo = 64'hFFFFFFFFFFFFFFFF; tg = 4'd3;
      in_v2 = 1'b1;
      tick();
      in_v2 = 1'b0;
      check("single_early", out_v2, 1'b0);
      tick();
      check("single_beat", {out_v2, out_hi2, out_lo2, out_tag2},
            {1'b1, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 4'd3});
      tick();
      check("single_gone", out_v2, 1'b0);

      // Full-rate streaming, tags 0..15
      k_hi = 64'hA5A5A5A5A5A5A5A5; k_lo = 64'h5A5A5A5A5A5A5A5A;
      for (int j = 0; j <= 16; j++) begin
         if (j < 16) begin
            in_v2 = 1'b1;
            tg    = 4'(j);
            d_hi  = 64'h0101010101010101 * j;
            d_lo  = ~d_hi;
         end else begin
            in_v2 = 1'b0;
         end
         tick();
         if (j >= 1) check($sformatf("stream_%0d", j-1), {out_v2, out_tag2, in_rdy2},
                           {1'b1, 4'(j-1), 1'b1});
      end
      tick();

      // Back-pressure: capacity 3, outputs frozen on beat 0
      out_rdy2 = 1'b0;
      in_v2    = 1'b1;
      acc      = 0;
      e_hi = 64'hB0B0000000000000 ^ k_hi;
      e_lo = 64'h0000000000000C0C ^ k_lo;
      for (int j = 0; j < 6; j++) begin
         tg   = 4'(8 + acc);
         d_hi = 64'hB0B0000000000000 | 64'(acc);
         d_lo = 64'h0000000000000C0C | (64'(acc) << 32);
         if (in_rdy2) acc++;
         tick();
         if (j >= 1) check($sformatf("stall_stable_%0d", j),
                           {out_v2, out_hi2, out_lo2, out_tag2}, {1'b1, e_hi, e_lo, 4'd8});
      end
      check("bp_accepted", acc, 3);
      check("bp_ready_low", {in_rdy2, busy2}, 2'b01);
      in_v2    = 1'b0;
      base     = n_out;
      out_rdy2 = 1'b1;
      repeat (4) tick();
      check("bp_drained", n_out - base, 3);

      // Random back-pressure against the scoreboard
      sent = 0; cyc = 0; base = n_out;
      k_hi = {$urandom(), $urandom()}; k_lo = {$urandom(), $urandom()};
      while (sent < 1000 && cyc < 20000) begin
         in_v2    = ($urandom_range(0, 3) != 0);
         out_rdy2 = 1'($urandom_range(0, 1));
         d_hi     = {$urandom(), $urandom()};
         d_lo     = {$urandom(), $urandom()};
         tg       = 4'($urandom_range(0, 15));
         if (in_v2 && in_rdy2) sent++;
         tick();
         cyc++;
      end
      in_v2 = 1'b0; out_rdy2 = 1'b1; cyc = 0;
      while (sb_q.size() != 0 && cyc < 100) begin
         tick();
         cyc++;
      end
      check("rand_sent", sent, 1000);
      check("rand_out", n_out - base, 1000);
      check("rand_q_empty", sb_q.size(), 0);

      // Reset with two beats in flight
      out_rdy2 = 1'b0;
      in_v2    = 1'b1;
      tick(); tick();
      in_v2 = 1'b0;
      check("pre_rst_busy", busy2, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid", {out_v2, busy2, in_rdy2}, 3'b001);
      out_rdy2 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check($sformatf("rst_no_stale_%0d", j), out_v2, 1'b0);
      end

      // STAGES=1: latency and capacity
      tg = 4'd7; in_v1 = 1'b1;
      tick();
      in_v1 = 1'b0; lat = 1;
      while (!out_v1 && lat < 10) begin tick(); lat++; end
      check("lat_s1", {lat[7:0], out_tag1}, {8'd1, 4'd7});
      tick();
      out_rdy1 = 1'b0; in_v1 = 1'b1; acc = 0;
      for (int j = 0; j < 8; j++) begin
         if (in_rdy1) acc++;
         tick();
      end
      in_v1 = 1'b0;
      check("cap_s1", acc, 2);

      // STAGES=4: latency and capacity
      tg = 4'd9; in_v4 = 1'b1;
      tick();
      in_v4 = 1'b0; lat = 1;
      while (!out_v4 && lat < 10) begin tick(); lat++; end
      check("lat_s4", {lat[7:0], out_tag4}, {8'd4, 4'd9});
      tick();
      out_rdy4 = 1'b0; in_v4 = 1'b1; acc = 0;
      for (int j = 0; j < 10; j++) begin
         if (in_rdy4) acc++;
         tick();
      end
      in_v4 = 1'b0;
      check("cap_s4", acc, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
